// File: rtl/sprite_pkg.sv
// Shared constants, FSM encoding and limit helper for the sprite motion controller.
//   VGA_WIDTH/VGA_HEIGHT : visible raster extent in pixels
//   SCALE_DIV_BITS       : extra shift folded into the on-screen size formula
//   state_e              : update-sequence FSM states
//   axis_limit()         : largest legal left/top coordinate for a given scale
package sprite_pkg;

    localparam int unsigned VGA_WIDTH      = 640;
    localparam int unsigned VGA_HEIGHT     = 480;
    localparam int unsigned SCALE_DIV_BITS = 8;
    localparam int unsigned COORD_W        = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC_S = 3'd1,
        CALC_X = 3'd2,
        CALC_Y = 3'd3,
        COMMIT = 3'd4
    } state_e;

    // extent - (1 << (size_bits + SCALE_DIV_BITS - scale)); oversize shifts give size 0
    function automatic logic signed [COORD_W-1:0] axis_limit(
        input int unsigned                extent,
        input int unsigned                size_bits,
        input logic signed [COORD_W-1:0]  scale
    );
        logic signed [COORD_W-1:0] shamt;
        logic signed [COORD_W-1:0] size;
        shamt = signed'(32'(size_bits + SCALE_DIV_BITS)) - scale;
        size  = signed'(32'd1 << shamt);
        return signed'(32'(extent)) - size;
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis position step with edge bounce (combinational).
//   pos        : current coordinate
//   vel        : current velocity
//   limit      : largest legal coordinate on this axis
//   pos_next_c : pos + vel clamped to [0, limit]
//   vel_next_c : velocity, forced to point back inward after a clamp
module sprite_axis_step
    import sprite_pkg::*;
(
    input  logic signed [COORD_W-1:0] pos,
    input  logic signed [COORD_W-1:0] vel,
    input  logic signed [COORD_W-1:0] limit,
    output logic signed [COORD_W-1:0] pos_next_c,
    output logic signed [COORD_W-1:0] vel_next_c
);

    logic signed [COORD_W-1:0] sum_c;
    logic signed [COORD_W-1:0] mag_c;

    // Inputs are 16/8-bit sign-extended, so the 32-bit sum cannot overflow.
    always_comb begin
        sum_c      = pos + vel;
        mag_c      = (vel < 0) ? -vel : vel;
        pos_next_c = sum_c;
        vel_next_c = vel;
        if (sum_c > limit) begin
            pos_next_c = limit;
            vel_next_c = -mag_c;
        end else if (sum_c < 0) begin
            pos_next_c = '0;
            vel_next_c = mag_c;
        end
    end

endmodule

// File: rtl/sprite_motion_controller.sv
// Per-frame sprite motion: bouncing x/y position plus a ping-ponging scale.
//   clk, reset         : clock and synchronous active-high reset
//   frame_start        : one-cycle pulse per video frame
//   enable             : frame updates accepted only while high
//   load, init_*       : one-cycle load of position/velocity (wins in any state)
//   x, y, scale        : sprite placement, updated together at COMMIT
//   busy               : update sequence in flight
//   frame_count        : completed frame updates (wraps)
module sprite_motion_controller #(
    parameter int SPRITE_SIZE_BITS = 6,
    parameter int SCALE_LO         = 7,
    parameter int SCALE_HI         = 9,
    parameter int SCALE_PERIOD     = 32,
    parameter int RESET_VX         = 1,
    parameter int RESET_VY         = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               enable,
    input  logic               load,
    input  logic signed [15:0] init_x,
    input  logic signed [15:0] init_y,
    input  logic signed [7:0]  init_vx,
    input  logic signed [7:0]  init_vy,
    output logic signed [31:0] x,
    output logic signed [31:0] y,
    output logic signed [31:0] scale,
    output logic               busy,
    output logic [31:0]        frame_count
);

    import sprite_pkg::*;

    localparam int unsigned CNT_W = $clog2(SCALE_PERIOD + 1);
    localparam logic [CNT_W-1:0]         CNT_TOP    = CNT_W'(SCALE_PERIOD);
    localparam logic signed [COORD_W-1:0] SCALE_LO_V = COORD_W'(SCALE_LO);
    localparam logic signed [COORD_W-1:0] SCALE_HI_V = COORD_W'(SCALE_HI);
    localparam logic signed [COORD_W-1:0] RESET_VX_V = COORD_W'(RESET_VX);
    localparam logic signed [COORD_W-1:0] RESET_VY_V = COORD_W'(RESET_VY);

    state_e state;
    state_e next_state;

    // Committed motion state not exposed on ports
    logic signed [COORD_W-1:0] vx;
    logic signed [COORD_W-1:0] vy;
    logic [CNT_W-1:0]          scale_cnt;
    logic                      scale_up;

    // Working copies built during the sequence; only COMMIT publishes them
    logic signed [COORD_W-1:0] scale_w;
    logic [CNT_W-1:0]          cnt_w;
    logic                      up_w;
    logic signed [COORD_W-1:0] x_w;
    logic signed [COORD_W-1:0] vx_w;
    logic signed [COORD_W-1:0] y_w;
    logic signed [COORD_W-1:0] vy_w;

    logic [CNT_W-1:0]          cnt_inc_c;
    logic [CNT_W-1:0]          cnt_step_c;
    logic signed [COORD_W-1:0] scale_step_c;
    logic                      up_step_c;
    logic signed [COORD_W-1:0] x_max_c;
    logic signed [COORD_W-1:0] y_max_c;
    logic signed [COORD_W-1:0] x_pos_c;
    logic signed [COORD_W-1:0] x_vel_c;
    logic signed [COORD_W-1:0] y_pos_c;
    logic signed [COORD_W-1:0] y_vel_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; load aborts any sequence and blocks a same-cycle start
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_start && enable && !load) next_state = CALC_S;
            CALC_S:  next_state = CALC_X;
            CALC_X:  next_state = CALC_Y;
            CALC_Y:  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (load) begin
            next_state = IDLE;
        end
    end

    // Scale counter step; direction flips when an end stop is reached
    always_comb begin
        cnt_inc_c    = scale_cnt + CNT_W'(1);
        cnt_step_c   = cnt_inc_c;
        scale_step_c = scale;
        up_step_c    = scale_up;
        if (cnt_inc_c == CNT_TOP) begin
            cnt_step_c   = '0;
            scale_step_c = scale_up ? (scale + 32'sd1) : (scale - 32'sd1);
            if (scale_step_c == SCALE_HI_V) begin
                up_step_c = 1'b0;
            end else if (scale_step_c == SCALE_LO_V) begin
                up_step_c = 1'b1;
            end
        end
    end

    // Bounds follow the scale computed for this frame, not the displayed one
    always_comb begin
        x_max_c = axis_limit(VGA_WIDTH,  int'(SPRITE_SIZE_BITS), scale_w);
        y_max_c = axis_limit(VGA_HEIGHT, int'(SPRITE_SIZE_BITS), scale_w);
    end

    sprite_axis_step u_step_x (
        .pos        (x),
        .vel        (vx),
        .limit      (x_max_c),
        .pos_next_c (x_pos_c),
        .vel_next_c (x_vel_c)
    );

    sprite_axis_step u_step_y (
        .pos        (y),
        .vel        (vy),
        .limit      (y_max_c),
        .pos_next_c (y_pos_c),
        .vel_next_c (y_vel_c)
    );

    // Datapath: build working values stage by stage, publish all at COMMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            vx          <= RESET_VX_V;
            vy          <= RESET_VY_V;
            scale       <= SCALE_LO_V;
            scale_cnt   <= '0;
            scale_up    <= 1'b1;
            frame_count <= '0;
            busy        <= 1'b0;
            scale_w     <= SCALE_LO_V;
            cnt_w       <= '0;
            up_w        <= 1'b1;
            x_w         <= '0;
            vx_w        <= '0;
            y_w         <= '0;
            vy_w        <= '0;
        end else begin
            busy <= (next_state != IDLE);
            if (load) begin
                x  <= 32'(init_x);
                y  <= 32'(init_y);
                vx <= 32'(init_vx);
                vy <= 32'(init_vy);
            end else begin
                case (state)
                    CALC_S: begin
                        scale_w <= scale_step_c;
                        cnt_w   <= cnt_step_c;
                        up_w    <= up_step_c;
                    end
                    CALC_X: begin
                        x_w  <= x_pos_c;
                        vx_w <= x_vel_c;
                    end
                    CALC_Y: begin
                        y_w  <= y_pos_c;
                        vy_w <= y_vel_c;
                    end
                    COMMIT: begin
                        x           <= x_w;
                        y           <= y_w;
                        vx          <= vx_w;
                        vy          <= vy_w;
                        scale       <= scale_w;
                        scale_cnt   <= cnt_w;
                        scale_up    <= up_w;
                        frame_count <= frame_count + 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Bench for sprite_motion_controller: directed vector table, hand-written
// corner sequences, and a randomized run against a frame-level model.
module tb_sprite_motion_controller;

    logic ext_clkv = 1'b0;
    always #5 ext_clkv = ~ext_clkv;

    logic               reset;
    logic               frame_start;
    logic               enable;
    logic               load;
    logic signed [15:0] init_x;
    logic signed [15:0] init_y;
    logic signed [7:0]  init_vx;
    logic signed [7:0]  init_vy;

    logic signed [31:0] d_x, d_y, d_scale;
    logic               d_busy;
    logic [31:0]        d_fc;
    logic signed [31:0] p_x, p_y, p_scale;
    logic               p_busy;
    logic [31:0]        p_fc;

    sprite_motion_controller u_dut (
        .clk(ext_clkv), .reset(reset), .frame_start(frame_start), .enable(enable),
        .load(load), .init_x(init_x), .init_y(init_y), .init_vx(init_vx), .init_vy(init_vy),
        .x(d_x), .y(d_y), .scale(d_scale), .busy(d_busy), .frame_count(d_fc)
    );

    sprite_motion_controller #(.SCALE_PERIOD(2)) u_dut_p2 (
        .clk(ext_clkv), .reset(reset), .frame_start(frame_start), .enable(enable),
        .load(load), .init_x(init_x), .init_y(init_y), .init_vx(init_vx), .init_vy(init_vy),
        .x(p_x), .y(p_y), .scale(p_scale), .busy(p_busy), .frame_count(p_fc)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ext_clkv);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; load = 1'b0; frame_start = 1'b0; enable = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input int ix, input int iy, input int ivx, input int ivy);
        init_x = 16'(ix); init_y = 16'(iy); init_vx = 8'(ivx); init_vy = 8'(ivy);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Pulse frame_start and count busy-high samples until idle (bounded)
    task automatic run_frame(input bit sel, output int nb);
        enable = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        nb = 0;
        for (int i = 0; i < 10; i++) begin
            if (sel ? p_busy : d_busy) nb++;
            else break;
            tick();
        end
    endtask

    // Frame-level reference model for SCALE_PERIOD = 2
    int m_x, m_y, m_vx, m_vy, m_scale, m_cnt, m_fc;
    bit m_up;

    function automatic void model_axis(inout int p, inout int v, input int lim);
        int s;
        int mag;
        s   = p + v;
        mag = (v < 0) ? -v : v;
        if (s > lim)      begin p = lim; v = -mag; end
        else if (s < 0)   begin p = 0;   v = mag;  end
        else              p = s;
    endfunction

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_vx = 1; m_vy = 1;
        m_scale = 7; m_cnt = 0; m_up = 1'b1; m_fc = 0;
    endfunction

    function automatic void model_frame();
        int size;
        m_cnt++;
        if (m_cnt == 2) begin
            m_cnt = 0;
            m_scale = m_up ? m_scale + 1 : m_scale - 1;
            if (m_scale == 9)      m_up = 1'b0;
            else if (m_scale == 7) m_up = 1'b1;
        end
        size = 1 << (6 + 8 - m_scale);
        model_axis(m_x, m_vx, 640 - size);
        model_axis(m_y, m_vy, 480 - size);
        m_fc++;
    endfunction

    function automatic int rand_pos();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 700)) - 40;
    endfunction

    function automatic int rand_vel();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255)) - 128;
        return int'($urandom_range(0, 24)) - 12;
    endfunction

    task automatic check_p2(input string tag);
        check({tag, " x"},     p_x,          m_x);
        check({tag, " y"},     p_y,          m_y);
        check({tag, " scale"}, p_scale,      m_scale);
        check({tag, " fc"},    32'(p_fc),    m_fc);
    endtask

    typedef struct {
        int ix, iy, ivx, ivy;
        int x1, y1, x2, y2;
    } vec_t;

    vec_t vecs[6];
    int   scale_seq[6];

    initial begin
        int nb;
        int ix, iy, ivx, ivy, op, k;

        // Scale 7: x_max = 512, y_max = 352
        vecs[0] = '{100,     50,    3,   -2, 103,  48, 106,  46};
        vecs[1] = '{510,     10,    5,    1, 512,  11, 507,  12};
        vecs[2] = '{20,       1,    1,   -3,  21,   0,  22,   3};
        vecs[3] = '{0,      352,   -1,    4,   0, 352,   1, 348};
        vecs[4] = '{-100,  1000,  127, -128,  27, 352, 154, 224};
        vecs[5] = '{30000, -30000, -7,    7, 512,   0, 505,   7};
        scale_seq[0] = 8; scale_seq[1] = 9; scale_seq[2] = 8;
        scale_seq[3] = 7; scale_seq[4] = 8; scale_seq[5] = 9;

        init_x = '0; init_y = '0; init_vx = '0; init_vy = '0;

        // Reset overrides a simultaneous load and frame_start
        reset = 1'b1; load = 1'b1; frame_start = 1'b1; enable = 1'b1;
        init_x = 16'sd77; init_y = 16'sd77;
        tick(); tick();
        check("rst_over_load x", d_x, 0);
        check("rst_over_load busy", 32'(d_busy), 0);
        apply_reset();
        check("reset x", d_x, 0);
        check("reset y", d_y, 0);
        check("reset scale", d_scale, 7);
        check("reset busy", 32'(d_busy), 0);
        check("reset fc", 32'(d_fc), 0);

        // Reset velocities of +1
        run_frame(1'b0, nb);
        check("reset_vel x", d_x, 1);
        check("reset_vel y", d_y, 1);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            do_load(vecs[i].ix, vecs[i].iy, vecs[i].ivx, vecs[i].ivy);
            check($sformatf("vec%0d load x", i), d_x, 32'(16'(vecs[i].ix)));
            run_frame(1'b0, nb);
            check($sformatf("vec%0d busy cycles", i), nb, 4);
            check($sformatf("vec%0d x1", i), d_x, vecs[i].x1);
            check($sformatf("vec%0d y1", i), d_y, vecs[i].y1);
            check($sformatf("vec%0d fc1", i), 32'(d_fc), 1);
            run_frame(1'b0, nb);
            check($sformatf("vec%0d x2", i), d_x, vecs[i].x2);
            check($sformatf("vec%0d y2", i), d_y, vecs[i].y2);
            check($sformatf("vec%0d fc2", i), 32'(d_fc), 2);
            check($sformatf("vec%0d scale", i), d_scale, 7);
        end

        // frame_start held high while busy: ignored, not queued; outputs change at N+4
        apply_reset();
        do_load(100, 50, 3, -2);
        frame_start = 1'b1;
        tick(); tick(); tick(); tick();
        check("busy_ignore x_at_n3", d_x, 100);
        check("busy_ignore busy_at_n3", 32'(d_busy), 1);
        frame_start = 1'b0;
        tick();
        check("busy_ignore x", d_x, 103);
        check("busy_ignore busy_at_n4", 32'(d_busy), 0);
        repeat (6) tick();
        check("busy_ignore fc", 32'(d_fc), 1);
        check("busy_ignore x_after", d_x, 103);

        // Load during CALC_X aborts the sequence
        apply_reset();
        do_load(100, 50, 3, -2);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        do_load(200, 60, -1, 1);
        check("abort busy", 32'(d_busy), 0);
        check("abort x", d_x, 200);
        check("abort y", d_y, 60);
        repeat (5) tick();
        check("abort fc", 32'(d_fc), 0);
        check("abort x_hold", d_x, 200);
        run_frame(1'b0, nb);
        check("abort next x", d_x, 199);
        check("abort next y", d_y, 61);
        check("abort next fc", 32'(d_fc), 1);

        // enable low: frame ignored
        enable = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("disabled busy", 32'(d_busy), 0);
        repeat (5) tick();
        enable = 1'b1;
        check("disabled x", d_x, 199);
        check("disabled fc", 32'(d_fc), 1);

        // load and frame_start together in IDLE: load only
        apply_reset();
        init_x = 16'sd5; init_y = 16'sd6; init_vx = 8'sd2; init_vy = 8'sd2;
        load = 1'b1; frame_start = 1'b1;
        tick();
        load = 1'b0; frame_start = 1'b0;
        check("load_fs busy", 32'(d_busy), 0);
        check("load_fs x", d_x, 5);
        repeat (5) tick();
        check("load_fs fc", 32'(d_fc), 0);
        check("load_fs x_hold", d_x, 5);

        // Reset mid-sequence
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset busy", 32'(d_busy), 0);
        check("mid_reset x", d_x, 0);
        repeat (5) tick();
        check("mid_reset fc", 32'(d_fc), 0);

        // Scale ping-pong with SCALE_PERIOD = 2
        apply_reset();
        model_reset();
        for (int i = 0; i < 6; i++) begin
            run_frame(1'b1, nb); model_frame();
            run_frame(1'b1, nb); model_frame();
            check($sformatf("scale_seq%0d", i), p_scale, scale_seq[i]);
        end
        check_p2("scale_seq model");

        // Randomized operations against the frame-level model
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                ix = rand_pos(); iy = rand_pos(); ivx = rand_vel(); ivy = rand_vel();
                do_load(ix, iy, ivx, ivy);
                m_x = ix; m_y = iy; m_vx = ivx; m_vy = ivy;
                check_p2("rnd load");
            end else if (op < 8) begin
                run_frame(1'b1, nb);
                model_frame();
                check("rnd busy cycles", nb, 4);
                check_p2("rnd frame");
            end else if (op == 8) begin
                enable = 1'b0;
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
                repeat (5) tick();
                enable = 1'b1;
                check("rnd disabled busy", 32'(p_busy), 0);
                check_p2("rnd disabled");
            end else begin
                k = int'($urandom_range(1, 4));
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
                repeat (k - 1) tick();
                ix = rand_pos(); iy = rand_pos(); ivx = rand_vel(); ivy = rand_vel();
                do_load(ix, iy, ivx, ivy);
                m_x = ix; m_y = iy; m_vx = ivx; m_vy = ivy;
                check("rnd abort busy", 32'(p_busy), 0);
                check_p2("rnd abort");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sprite_motion_controller.md
SPRITE_MOTION_CONTROLLER -- requirements
Module: sprite_motion_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SPRITE_SIZE_BITS, 6, log2 of sprite bitmap edge length.
- SCALE_LO, 7, minimum scale (largest on-screen sprite).
- SCALE_HI, 9, maximum scale (smallest on-screen sprite).
- SCALE_PERIOD, 32, frames between scale steps, >=1.
- RESET_VX, 1, reset x velocity.
- RESET_VY, 1, reset y velocity.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- frame_start, in, 1, one-cycle pulse per video frame (clk domain).
- enable, in, 1, frame updates allowed when high.
- load, in, 1, one-cycle pulse to load init_* values.
- init_x, in, 16 signed, load value for x.
- init_y, in, 16 signed, load value for y.
- init_vx, in, 8 signed, load value for vx.
- init_vy, in, 8 signed, load value for vy.
- x, out, 32 signed, sprite left edge to sprite x input.
- y, out, 32 signed, sprite top edge to sprite y input.
- scale, out, 32 signed, sprite scale input.
- busy, out, 1, update sequence in progress.
- frame_count, out, 32, accepted frame updates, wraps.
REQ-003 Clock port is named clk; reset port is named reset; reset is synchronous and active-high.

Function
REQ-004 On-screen size SHALL be size = 1 << (SPRITE_SIZE_BITS + 8 - scale); x_max = 640 - size; y_max = 480 - size.
REQ-005 FSM states SHALL be IDLE, CALC_S, CALC_X, CALC_Y, COMMIT; IDLE->CALC_S on frame_start && enable && !load; every other state advances unconditionally; COMMIT->IDLE.
REQ-006 CALC_S: the scale counter increments; on reaching SCALE_PERIOD it clears and scale steps by +1 or -1 per direction; direction reverses on reaching SCALE_HI or SCALE_LO.
REQ-007 CALC_X: nx = x + vx using the new scale's x_max; nx > x_max gives nx = x_max, vx = -|vx|; nx < 0 gives nx = 0, vx = +|vx|.
REQ-008 CALC_Y: same rule as REQ-007 with y, vy, y_max.
REQ-009 COMMIT: x, y, scale outputs update together on one edge, and frame_count increments; outputs never show a partial update.
REQ-010 Latency: frame_start sampled at edge N; outputs change at edge N+4; busy is high for edges N+1..N+4 inclusive (4 cycles).
REQ-011 frame_start arriving while busy, or while enable is low, SHALL be ignored with no queuing.
REQ-012 load SHALL win in any state: x, y, vx, vy take the init_* values (sign-extended) on the next edge, and the FSM goes to IDLE, aborting any sequence; scale and frame_count are unchanged.
REQ-013 load and frame_start together in IDLE: load only.
REQ-014 Arithmetic SHALL be 32-bit signed with no overflow wrap; clamp bounds always apply.

Reset
REQ-015 On reset: state=IDLE, x=0, y=0, vx=RESET_VX, vy=RESET_VY, scale=SCALE_LO, direction up, scale counter=0, frame_count=0, busy=0.
REQ-016 Reset SHALL override load and frame_start in the same cycle, and aborts any sequence in progress.

Structure
REQ-017 Package sprite_pkg SHALL hold VGA_WIDTH=640, VGA_HEIGHT=480, SCALE_DIV_BITS=8, and the FSM state encoding.
REQ-018 Sub-module sprite_axis_step (position, velocity, limit -> clamped position, velocity) SHALL be combinational and instantiated twice (x, y).

Verification
REQ-019 Reset release -> x=0, y=0, scale=7, busy=0, frame_count=0.
REQ-020 Load (100,50,3,-2), then frame_start -> 4 cycles later x=103, y=48; busy high exactly 4 cycles; frame_count=1.
REQ-021 scale=7 (x_max=512); load x=510, vx=5; frame -> x=512, vx=-5; next frame -> x=507.
REQ-022 Load y=1, vy=-3; frame -> y=0, next frame -> y=3.
REQ-023 SCALE_PERIOD=2; 12 frames -> scale sequence after each pair: 8, 9, 8, 7, 8, 9.
REQ-024 frame_start while busy -> ignored, frame_count +1 only; load at CALC_X -> init values, IDLE, frame_count unchanged; enable=0 -> no change.
